// File: rtl/dbus_pkg.sv
// dbus_pkg: shared types and constants for the data-bus controller.
// Holds the arbitration FSM state enum, the MMIO register byte offsets,
// the default MMIO window base and a helper that maps a byte offset to its word slot.
package dbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // core owns the bus
    GNT  = 2'd1,  // loader access executes this cycle
    RESP = 2'd2   // loader result presented, core owns the bus
  } state_t;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_FF00;

  localparam logic [7:0] OFS_LED      = 8'h00;
  localparam logic [7:0] OFS_SW       = 8'h04;
  localparam logic [7:0] OFS_KEY      = 8'h08;
  localparam logic [7:0] OFS_KEY_EDGE = 8'h0C;
  localparam logic [7:0] OFS_CYCLE    = 8'h10;

  // Registers are word-wide; the two byte-lane bits play no part in decode.
  function automatic logic [5:0] ofs_word(input logic [7:0] ofs);
    return ofs[7:2];
  endfunction

endpackage

// File: rtl/dbus_mmio.sv
// dbus_mmio: board I/O register block behind the MMIO window.
// Latency: reads combinational, writes commit at the next rising edge; no backpressure.
// Ports: clk/reset; single access port (we, offset, wdata, rdata); sw/key pins; led register.
// Optional macro KEY_EDGE_EN adds the sticky, write-1-to-clear KEY_EDGE register at 0x0C.
module dbus_mmio
  import dbus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,   // asynchronous, active-low
  input  logic        we,      // already qualified by the MMIO window match
  input  logic [7:0]  offset,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [9:0]  sw,
  input  logic [2:0]  key,
  output logic [9:0]  led
);

  localparam logic [5:0] W_LED      = ofs_word(OFS_LED);
  localparam logic [5:0] W_SW       = ofs_word(OFS_SW);
  localparam logic [5:0] W_KEY      = ofs_word(OFS_KEY);
  localparam logic [5:0] W_KEY_EDGE = ofs_word(OFS_KEY_EDGE);
  localparam logic [5:0] W_CYCLE    = ofs_word(OFS_CYCLE);

  logic [5:0]  word;
  logic [9:0]  sw_meta, sw_sync;
  logic [2:0]  key_meta, key_sync;
  logic [9:0]  led_q;
  logic [31:0] cycle_q;
  logic [2:0]  key_edge_rd;

  assign word = offset[7:2];
  assign led  = led_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      key_meta <= 3'b111;   // keys idle released (active-low pins)
      key_sync <= 3'b111;
      led_q    <= '0;
      cycle_q  <= '0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      key_meta <= key;
      key_sync <= key_meta;
      cycle_q  <= cycle_q + 32'd1;
      if (we && word == W_LED) led_q <= wdata[9:0];
    end
  end

`ifdef KEY_EDGE_EN
  logic [2:0] key_prev, key_edge_q, press, clr;

  // Press = released (1) on the previous synchronized sample, pressed (0) now.
  assign press = key_prev & ~key_sync;
  assign clr   = (we && word == W_KEY_EDGE) ? wdata[2:0] : 3'b000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_prev   <= 3'b111;
      key_edge_q <= '0;
    end else begin
      key_prev   <= key_sync;
      // OR-ing press last lets a coincident edge beat the clear.
      key_edge_q <= (key_edge_q & ~clr) | press;
    end
  end

  assign key_edge_rd = key_edge_q;
`else
  assign key_edge_rd = 3'b000;
`endif

  always_comb begin
    rdata = '0;
    case (word)
      W_LED:      rdata = {22'b0, led_q};
      W_SW:       rdata = {22'b0, sw_sync};
      W_KEY:      rdata = {29'b0, ~key_sync};
      W_KEY_EDGE: rdata = {29'b0, key_edge_rd};
      W_CYCLE:    rdata = cycle_q;
      default:    rdata = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{wdata[31:10], offset[1:0]};

endmodule

// File: rtl/dbus_ctrl.sv
// dbus_ctrl: data-bus controller sharing data memory and MMIO between core and loader.
// Latency: core access zero-latency; loader ld_gnt at +1, ld_valid/ld_rdata at +2 after ld_req.
// Backpressure: cpu_stall for the single GNT cycle; core gets >=2 free cycles between grants.
// Ports: clk/reset (async active-low); cpu_* core port; ld_* loader port; mem_* memory port;
// sw/key pins, led register. Optional macro KEY_EDGE_EN enables the KEY_EDGE register.
module dbus_ctrl
  import dbus_pkg::*;
#(
  parameter int          DMEM_AW   = 6,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_gnt,
  output logic [31:0] ld_rdata,
  output logic        ld_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic [9:0]  sw,
  input  logic [2:0]  key,
  output logic [9:0]  led
);

  state_t      state, state_nxt;
  logic        bus_ld, bus_we, is_mmio;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, mmio_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_gnt    = 1'b0;
    ld_valid  = 1'b0;
    cpu_stall = 1'b0;
    case (state)
      IDLE: if (ld_req) state_nxt = GNT;
      GNT: begin
        state_nxt = RESP;
        ld_gnt    = 1'b1;
        cpu_stall = 1'b1;
      end
      RESP: begin
        state_nxt = IDLE;
        ld_valid  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only the GNT cycle hands the bus to the loader; the core's store is
  // dropped by the mux itself, so no separate blocking term is needed.
  assign bus_ld    = (state == GNT);
  assign bus_we    = bus_ld ? ld_we    : cpu_we;
  assign bus_addr  = bus_ld ? ld_addr  : cpu_addr;
  assign bus_wdata = bus_ld ? ld_wdata : cpu_wdata;

  assign is_mmio   = (bus_addr[31:8] == MMIO_BASE[31:8]);

  // Memory indexes with addr[DMEM_AW+1:2]; the full byte address is passed through.
  assign mem_we    = bus_we & ~is_mmio;
  assign mem_addr  = bus_addr;
  assign mem_wdata = bus_wdata;

  assign bus_rdata = is_mmio ? mmio_rdata : mem_rdata;
  assign cpu_rdata = bus_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ld_rdata <= '0;
    else if (bus_ld) ld_rdata <= bus_rdata;
  end

  dbus_mmio u_mmio (
    .clk    (clk),
    .reset  (reset),
    .we     (bus_we & is_mmio),
    .offset (bus_addr[7:0]),
    .wdata  (bus_wdata),
    .rdata  (mmio_rdata),
    .sw     (sw),
    .key    (key),
    .led    (led)
  );

  logic unused_cfg;
  assign unused_cfg = (DMEM_AW > 0);

endmodule

// File: tb/tb_dbus_ctrl.sv
// tb_dbus_ctrl: randomized self-checking bench for dbus_ctrl against a behavioural model.
// The model keeps expected memory words and the LED value; timing expectations come from
// the loader handshake rules (gnt at +1, valid at +2, grants 3 cycles apart under held req).
module tb_dbus_ctrl;

  localparam logic [31:0] MB = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we, cpu_stall, ld_req, ld_we, ld_gnt, ld_valid, mem_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, ld_addr, ld_wdata, ld_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [9:0]  sw, led;
  logic [2:0]  key;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  logic [31:0] ref_mem [0:63];
  logic [9:0]  ref_led;

  always #5 clk = ~clk;

  dbus_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_valid(ld_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .sw(sw), .key(key), .led(led)
  );

  // Single-port data memory with asynchronous read, as the board provides it.
  logic [31:0] dmem [0:63];
  always @(posedge clk) if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
  assign mem_rdata = dmem[mem_addr[7:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_addr_of(input logic [5:0] idx);
    logic [23:0] up;
    up = 24'($urandom_range(0, 24'hFFFFFE));
    return {up, idx, 2'($urandom_range(0, 3))};
  endfunction

  task automatic ld_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output logic g0, output logic g1, output logic s1,
                        output logic w1, output logic v2, output logic [31:0] rd);
    ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d;
    @(negedge clk); g0 = ld_gnt;
    tick();
    @(negedge clk); g1 = ld_gnt; s1 = cpu_stall; w1 = mem_we;
    tick();
    ld_req = 1'b0;
    @(negedge clk); v2 = ld_valid; rd = ld_rdata;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; sw = '0; key = 3'b111;
    cpu_we = 0; cpu_addr = MB | 32'h10; cpu_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    repeat (3) tick();
    @(negedge clk);
    n_total++; if (ld_gnt !== 1'b0) $display("FAIL rst_gnt got %b exp 0", ld_gnt); else n_pass++;
    n_total++; if (ld_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", ld_valid); else n_pass++;
    n_total++; if (cpu_stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", cpu_stall); else n_pass++;
    n_total++; if (led !== 10'h0) $display("FAIL rst_led got %h exp 0", led); else n_pass++;
    n_total++; if (ld_rdata !== 32'h0) $display("FAIL rst_ld_rdata got %h exp 0", ld_rdata); else n_pass++;
    n_total++; if (cpu_rdata !== 32'h0) $display("FAIL rst_cycle got %h exp 0", cpu_rdata); else n_pass++;
    cpu_addr = MB | 32'h08;
    #1;
    n_total++; if (cpu_rdata !== 32'h0) $display("FAIL rst_key got %h exp 0", cpu_rdata); else n_pass++;
    tick();
    reset = 1'b1; cpu_addr = MB | 32'h10;
    repeat (5) tick();
    @(negedge clk);
    n_total++; if (cpu_rdata !== 32'd5) $display("FAIL cycle_count got %0d exp 5", cpu_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_core_rw();
    logic [5:0]  idx;
    logic [31:0] d, a;
    for (int i = 0; i < 64; i++) begin
      idx = 6'(i); d = (i == 4) ? 32'hDEAD_BEEF : $urandom;
      a = (i == 4) ? 32'h10 : mem_addr_of(idx);
      cpu_we = 1; cpu_addr = a; cpu_wdata = d;
      @(negedge clk);
      n_total++; if (cpu_stall !== 1'b0 || mem_we !== 1'b1) $display("FAIL core_wr stall=%b mem_we=%b exp 0/1", cpu_stall, mem_we); else n_pass++;
      tick();
      ref_mem[idx] = d;
      if (i == 4) begin
        cpu_we = 0; cpu_addr = 32'h10;
        @(negedge clk);
        n_total++; if (cpu_rdata !== 32'hDEAD_BEEF) $display("FAIL core_deadbeef got %h exp deadbeef", cpu_rdata); else n_pass++;
        tick();
      end
    end
    cpu_we = 0;
    for (int i = 0; i < 24; i++) begin
      idx = 6'($urandom_range(0, 63));
      cpu_addr = mem_addr_of(idx);
      @(negedge clk);
      n_total++; if (cpu_rdata !== ref_mem[idx] || cpu_stall !== 1'b0) $display("FAIL core_rd[%0d] got %h stall=%b exp %h", idx, cpu_rdata, cpu_stall, ref_mem[idx]); else n_pass++;
      tick();
    end
  endtask

  task automatic test_mmio();
    logic [9:0] v, s, s_prev;
    for (int i = 0; i < 2; i++) begin
      v = (i == 0) ? 10'h3FF : 10'($urandom);
      cpu_we = 1; cpu_addr = MB; cpu_wdata = {22'($urandom), v};
      @(negedge clk);
      n_total++; if (mem_we !== 1'b0) $display("FAIL mmio_mem_we got %b exp 0", mem_we); else n_pass++;
      tick();
      cpu_we = 0; ref_led = v; cpu_addr = MB | 32'h1;
      @(negedge clk);
      n_total++; if (led !== v || cpu_rdata !== {22'b0, v}) $display("FAIL led got %h rd %h exp %h", led, cpu_rdata, v); else n_pass++;
      tick();
    end
    s_prev = sw;
    for (int i = 0; i < 2; i++) begin
      s = (i == 0) ? 10'h155 : 10'($urandom);
      sw = s; cpu_addr = MB | 32'h04;
      tick();
      @(negedge clk);
      n_total++; if (cpu_rdata !== {22'b0, s_prev}) $display("FAIL sw_lag got %h exp %h", cpu_rdata, s_prev); else n_pass++;
      tick();
      @(negedge clk);
      n_total++; if (cpu_rdata !== {22'b0, s}) $display("FAIL sw got %h exp %h", cpu_rdata, s); else n_pass++;
      tick();
      s_prev = s;
    end
    cpu_we = 1; cpu_wdata = ~{22'b0, s_prev};
    tick();
    cpu_we = 0;
    @(negedge clk);
    n_total++; if (cpu_rdata !== {22'b0, s_prev} || led !== ref_led) $display("FAIL sw_ro got %h led %h exp %h/%h", cpu_rdata, led, s_prev, ref_led); else n_pass++;
    tick();
    key = 3'b101; cpu_addr = MB | 32'h08;
    repeat (2) tick();
    @(negedge clk);
    n_total++; if (cpu_rdata !== 32'h2) $display("FAIL key got %h exp 2", cpu_rdata); else n_pass++;
    tick();
    key = 3'b111;
    repeat (2) tick();
    @(negedge clk);
    n_total++; if (cpu_rdata !== 32'h0) $display("FAIL key_rel got %h exp 0", cpu_rdata); else n_pass++;
    tick();
    cpu_we = 1; cpu_addr = MB | 32'h14; cpu_wdata = 32'hFFFF_FFFF;
    tick();
    cpu_we = 0;
    @(negedge clk);
    n_total++; if (cpu_rdata !== 32'h0 || led !== ref_led) $display("FAIL unmapped got %h led %h exp 0/%h", cpu_rdata, led, ref_led); else n_pass++;
    tick();
    // Top word just below the window must still be ordinary memory.
    cpu_we = 1; cpu_addr = 32'hFFFF_FEFC; cpu_wdata = $urandom;
    @(negedge clk);
    n_total++; if (mem_we !== 1'b1) $display("FAIL below_window mem_we got %b exp 1", mem_we); else n_pass++;
    tick();
    ref_mem[63] = cpu_wdata; cpu_we = 0;
    @(negedge clk);
    n_total++; if (cpu_rdata !== ref_mem[63]) $display("FAIL below_window got %h exp %h", cpu_rdata, ref_mem[63]); else n_pass++;
    tick();
  endtask

  task automatic test_key_edge();
    cpu_we = 1; cpu_addr = MB | 32'h0C; cpu_wdata = 32'h7;
    tick();
    cpu_we = 0;
`ifdef KEY_EDGE_EN
    @(negedge clk);
    n_total++; if (cpu_rdata !== 32'h0) $display("FAIL kedge_clr_all got %h exp 0", cpu_rdata); else n_pass++;
    tick();
    key = 3'b101;
    repeat (4) tick();
    @(negedge clk);
    n_total++; if (cpu_rdata !== 32'h2) $display("FAIL kedge_set got %h exp 2", cpu_rdata); else n_pass++;
    tick();
    key = 3'b111; cpu_we = 1; cpu_wdata = 32'h1;
    tick();
    cpu_we = 0;
    @(negedge clk);
    n_total++; if (cpu_rdata !== 32'h2) $display("FAIL kedge_sticky got %h exp 2", cpu_rdata); else n_pass++;
    tick();
    cpu_we = 1; cpu_wdata = 32'h2;
    tick();
    cpu_we = 0;
    repeat (3) tick();
    @(negedge clk);
    n_total++; if (cpu_rdata !== 32'h0) $display("FAIL kedge_w1c got %h exp 0", cpu_rdata); else n_pass++;
    tick();
    key = 3'b101;
    repeat (2) tick();
    cpu_we = 1; cpu_wdata = 32'h2;
    tick();
    cpu_we = 0;
    @(negedge clk);
    n_total++; if (cpu_rdata !== 32'h2) $display("FAIL kedge_collide got %h exp 2", cpu_rdata); else n_pass++;
    tick();
    key = 3'b111; cpu_we = 1; cpu_wdata = 32'h7;
    tick();
    cpu_we = 0;
    repeat (3) tick();
`else
    key = 3'b101;
    repeat (4) tick();
    @(negedge clk);
    n_total++; if (cpu_rdata !== 32'h0) $display("FAIL kedge_off got %h exp 0", cpu_rdata); else n_pass++;
    tick();
    key = 3'b111;
    repeat (3) tick();
`endif
  endtask

  task automatic test_loader();
    logic g0, g1, s1, w1, v2;
    logic [31:0] rd, d;
    logic [5:0]  idx;
    ld_txn(1'b1, 32'h20, 32'h1234_5678, g0, g1, s1, w1, v2, rd);
    ref_mem[8] = 32'h1234_5678;
    n_total++; if (g0 !== 1'b0 || g1 !== 1'b1) $display("FAIL ldw_gnt got n=%b n+1=%b exp 0/1", g0, g1); else n_pass++;
    n_total++; if (s1 !== 1'b1 || w1 !== 1'b1) $display("FAIL ldw_stall_we got %b/%b exp 1/1", s1, w1); else n_pass++;
    n_total++; if (v2 !== 1'b1) $display("FAIL ldw_valid got %b exp 1", v2); else n_pass++;
    cpu_addr = 32'h20;
    @(negedge clk);
    n_total++; if (ld_valid !== 1'b0 || cpu_stall !== 1'b0 || mem_we !== 1'b0) $display("FAIL ldw_after valid=%b stall=%b we=%b exp 0", ld_valid, cpu_stall, mem_we); else n_pass++;
    n_total++; if (cpu_rdata !== 32'h1234_5678) $display("FAIL ldw_readback got %h exp 12345678", cpu_rdata); else n_pass++;
    tick();
    idx = 6'($urandom_range(0, 63));
    ld_txn(1'b0, mem_addr_of(idx), 32'h0, g0, g1, s1, w1, v2, rd);
    n_total++; if (g1 !== 1'b1 || v2 !== 1'b1 || rd !== ref_mem[idx]) $display("FAIL ldr_mem gnt=%b valid=%b got %h exp %h", g1, v2, rd, ref_mem[idx]); else n_pass++;
    d = $urandom;
    ld_txn(1'b1, MB, d, g0, g1, s1, w1, v2, rd);
    ref_led = d[9:0];
    n_total++; if (w1 !== 1'b0 || led !== ref_led) $display("FAIL ldw_led mem_we=%b led %h exp 0/%h", w1, led, ref_led); else n_pass++;
    ld_txn(1'b0, MB | 32'h2, 32'h0, g0, g1, s1, w1, v2, rd);
    n_total++; if (rd !== {22'b0, ref_led}) $display("FAIL ldr_led got %h exp %h", rd, ref_led); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] idx, tidx;
    logic       exp_g, exp_v;
    int         ngnt;
    idx = 6'($urandom_range(0, 63)); tidx = 6'($urandom_range(0, 63));
    ngnt = 0;
    ld_we = 0; ld_addr = mem_addr_of(idx);
    for (int c = 0; c < 10; c++) begin
      exp_g = (c == 1 || c == 4 || c == 7);
      exp_v = (c == 2 || c == 5 || c == 8);
      ld_req = (c < 8);
      cpu_we = exp_g; cpu_addr = mem_addr_of(tidx); cpu_wdata = ~ref_mem[tidx];
      @(negedge clk);
      if (ld_gnt === 1'b1) ngnt++;
      n_total++; if (ld_gnt !== exp_g || cpu_stall !== exp_g || ld_valid !== exp_v) $display("FAIL b2b_c%0d gnt=%b stall=%b valid=%b exp %b/%b/%b", c, ld_gnt, cpu_stall, ld_valid, exp_g, exp_g, exp_v); else n_pass++;
      if (exp_v) begin
        n_total++; if (ld_rdata !== ref_mem[idx]) $display("FAIL b2b_rdata got %h exp %h", ld_rdata, ref_mem[idx]); else n_pass++;
      end
      tick();
    end
    cpu_we = 0; ld_req = 0; cpu_addr = mem_addr_of(tidx);
    @(negedge clk);
    n_total++; if (ngnt != 3) $display("FAIL b2b_count got %0d exp 3", ngnt); else n_pass++;
    n_total++; if (cpu_rdata !== ref_mem[tidx]) $display("FAIL b2b_blocked_store got %h exp %h", cpu_rdata, ref_mem[tidx]); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic g0, g1, s1, w1, v2;
    logic [31:0] rd, d;
    logic [5:0]  idx;
    for (int i = 0; i < 40; i++) begin
      idx = 6'($urandom_range(0, 63)); d = $urandom;
      case ($urandom_range(0, 3))
        0: begin
          cpu_we = 1; cpu_addr = mem_addr_of(idx); cpu_wdata = d;
          tick();
          cpu_we = 0; ref_mem[idx] = d;
        end
        1: begin
          cpu_addr = mem_addr_of(idx);
          @(negedge clk);
          n_total++; if (cpu_rdata !== ref_mem[idx] || cpu_stall !== 1'b0) $display("FAIL rnd_core_rd[%0d] got %h exp %h", idx, cpu_rdata, ref_mem[idx]); else n_pass++;
          tick();
        end
        2: begin
          ld_txn(1'b1, mem_addr_of(idx), d, g0, g1, s1, w1, v2, rd);
          ref_mem[idx] = d;
          n_total++; if (g0 !== 1'b0 || g1 !== 1'b1 || w1 !== 1'b1 || v2 !== 1'b1) $display("FAIL rnd_ldw g=%b%b we=%b v=%b exp 01/1/1", g0, g1, w1, v2); else n_pass++;
        end
        default: begin
          ld_txn(1'b0, mem_addr_of(idx), 32'h0, g0, g1, s1, w1, v2, rd);
          n_total++; if (g1 !== 1'b1 || v2 !== 1'b1 || rd !== ref_mem[idx]) $display("FAIL rnd_ldr[%0d] got %h exp %h", idx, rd, ref_mem[idx]); else n_pass++;
        end
      endcase
    end
  endtask

  task automatic test_reset_in_gnt();
    logic [5:0] idx;
    cpu_we = 1; cpu_addr = MB; cpu_wdata = 32'h2A5;
    tick();
    cpu_we = 0; ref_led = 10'h2A5;
    idx = 6'($urandom_range(0, 63));
    ld_req = 1; ld_we = 1; ld_addr = mem_addr_of(idx); ld_wdata = ~ref_mem[idx];
    tick();
    n_total++; if (ld_gnt !== 1'b1 || led !== ref_led) $display("FAIL rgnt_pre gnt=%b led=%h exp 1/%h", ld_gnt, led, ref_led); else n_pass++;
    reset = 1'b0; cpu_addr = MB | 32'h10;
    #1;
    n_total++; if (ld_gnt !== 1'b0 || ld_valid !== 1'b0 || cpu_stall !== 1'b0) $display("FAIL rgnt_ctl gnt=%b valid=%b stall=%b exp 0", ld_gnt, ld_valid, cpu_stall); else n_pass++;
    n_total++; if (led !== 10'h0 || cpu_rdata !== 32'h0 || ld_rdata !== 32'h0) $display("FAIL rgnt_regs led=%h cycle=%h ldr=%h exp 0", led, cpu_rdata, ld_rdata); else n_pass++;
    ld_req = 0;
    tick();
    reset = 1'b1; ld_req = 1; ld_we = 0;
    @(negedge clk);
    n_total++; if (ld_valid !== 1'b0 || ld_gnt !== 1'b0) $display("FAIL rgnt_rel0 valid=%b gnt=%b exp 0", ld_valid, ld_gnt); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (ld_gnt !== 1'b1 || ld_valid !== 1'b0) $display("FAIL rgnt_rel1 gnt=%b valid=%b exp 1/0", ld_gnt, ld_valid); else n_pass++;
    tick();
    ld_req = 0;
    @(negedge clk);
    n_total++; if (ld_valid !== 1'b1 || ld_rdata !== ref_mem[idx]) $display("FAIL rgnt_rel2 valid=%b got %h exp 1/%h", ld_valid, ld_rdata, ref_mem[idx]); else n_pass++;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_core_rw();
    test_mmio();
    test_key_edge();
    test_loader();
    test_back_to_back();
    test_random();
    test_reset_in_gnt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
